dcm_reset_seq: RTL and testbench
================================

# dcm_reset_seq

Reset sequencer directly downstream of the DCM clock generator. It consumes the generator's combined `LOCKED`, drives the generator's DCM reset input, and holds the system reset until lock has been stable for a programmable time. On loss of lock it automatically re-resets the DCMs and counts retries. It runs on the buffered 13 MHz input clock, which is valid before any DCM locks.

## Interface
- `RST_CYCLES`, 4: DCM reset pulse length in `CLOCK_13` cycles; must be ≥ 3, the DCM_SP minimum.
- `LOCK_TIMEOUT`, 65536: cycles to wait for lock before retrying (≈5 ms).
- `STABLE_CYCLES`, 1024: cycles lock must hold continuously before release.
- `MAX_RETRIES`, 15: retry limit, used only when the limit feature is compiled in; ≤ 255.
- `TMR_W`, 17: shared timer width; must hold max(`RST_CYCLES`, `LOCK_TIMEOUT`, `STABLE_CYCLES`) − 1.
- `CLOCK_13`  in  1  buffered 13 MHz clock; the only clock.
- `RST`  in  1  reset; synchronous, active-high.
- `LOCKED_IN`  in  1  combined DCM lock; asynchronous to `CLOCK_13`.
- `DCM_RST`  out  1  drives the clock generator's `RST`.
- `SYS_RST`  out  1  system reset; high unless in RUN.
- `READY`  out  1  high only in RUN.
- `FAIL`  out  1  high only in FAIL.
- `RETRY_CNT`  out  8  number of retries since `RST`; saturates at 255.

## Operation
- `LOCKED_IN` passes through a 2-flop synchronizer to give `lock_s`. `lock_s` resets to 0.
- FSM states: DRST, WAIT, STABLE, RUN, FAIL. All outputs are Moore decodes of the state register, plus `RETRY_CNT`:
  - `DCM_RST` = DRST or FAIL.
  - `SYS_RST` = not RUN.
  - `READY` = RUN.
  - `FAIL` = FAIL.
- `RST` has priority over every transition: state ← DRST, timer ← 0, `RETRY_CNT` ← 0, synchronizer flops ← 0.
- Reset output values: `DCM_RST`=1, `SYS_RST`=1, `READY`=0, `FAIL`=0, `RETRY_CNT`=0.
- **DRST**: increment the timer. When the timer reaches `RST_CYCLES`−1, go to WAIT and set timer ← 0. `lock_s` is ignored in this state.
- **WAIT**:
  - `lock_s`=1 → STABLE, timer ← 0.
  - Otherwise, timer == `LOCK_TIMEOUT`−1 → RETRY path.
  - Otherwise, timer++.
- **STABLE**:
  - `lock_s`=0 → WAIT, timer ← 0. This is not a retry and does not change `RETRY_CNT`.
  - Otherwise, timer == `STABLE_CYCLES`−1 → RUN.
  - Otherwise, timer++.
- **RUN**: `lock_s`=0 → RETRY path. The timer is idle.
- **RETRY path** (a transition, not a state):
  - If the limit is compiled in and `RETRY_CNT` ≥ `MAX_RETRIES` → FAIL.
  - Otherwise → DRST, timer ← 0, `RETRY_CNT` ← saturating +1.
- **FAIL**: terminal until `RST`. Keeps the DCMs in reset; `LOCKED_IN` is ignored.

## Timing
- `DCM_RST` is high for exactly `RST_CYCLES` cycles per DRST visit, starting in the first cycle after `RST` deasserts.
- Synchronizer latency: a `LOCKED_IN` edge is seen by the FSM 2 cycles later.
- `SYS_RST` falls `STABLE_CYCLES`+3 cycles after `LOCKED_IN` rises (sampled while in WAIT): 2 synchronizer + 1 WAIT→STABLE + `STABLE_CYCLES` in STABLE.
- A lock drop in RUN raises `SYS_RST` and `DCM_RST` 3 cycles after `LOCKED_IN` falls.
- Glitches shorter than one cycle may be missed. Any low `lock_s` sample in STABLE or RUN counts as a loss.

## Configuration
- Macro `DCM_RESET_SEQ_RETRY_LIMIT_EN`.
- Defined: the RETRY path enters FAIL once `RETRY_CNT` ≥ `MAX_RETRIES`.
- Undefined: the FAIL state is never entered, retries continue indefinitely, `FAIL` is tied to 0, and `RETRY_CNT` still counts and saturates.

## Structure
- Package `dcm_reset_seq_pkg` holds the state encodings (3-bit: DRST=0, WAIT=1, STABLE=2, RUN=3, FAIL=4) and the `RETRY_CNT` width constant (8).
- One sub-module, `sync_bit`: a 2-flop synchronizer with synchronous reset to 0. It is reusable by other cross-domain status bits.

## Test plan
Parameters for all scenarios: `RST_CYCLES`=4, `LOCK_TIMEOUT`=32, `STABLE_CYCLES`=8, `MAX_RETRIES`=2, limit enabled.
1. Release `RST`, raise `LOCKED_IN` 10 cycles later → `DCM_RST` high for exactly 4 cycles, `SYS_RST` falls 11 cycles after the `LOCKED_IN` rise, `READY`=1, `RETRY_CNT`=0.
2. Hold `LOCKED_IN`=0 → `DCM_RST` re-pulses every 4+32 cycles, `RETRY_CNT` reaches 2, then `FAIL`=1, `DCM_RST`=1, `SYS_RST`=1 persisting; assert `RST` → all outputs return to their reset values.
3. In RUN, drop `LOCKED_IN` for 1 cycle → `SYS_RST`=1 3 cycles later, 4-cycle `DCM_RST` pulse, `RETRY_CNT`=1; relock → RUN again.
4. Drop `LOCKED_IN` for 1 cycle at STABLE timer = 5 → returns to WAIT with no `DCM_RST` pulse and `RETRY_CNT` unchanged; `SYS_RST` falls 11 cycles after relock.
5. Assert `RST` mid-DRST and mid-RUN → next cycle state is DRST, timer=0, `RETRY_CNT`=0.
6. Build with the macro undefined and hold `LOCKED_IN` low for 20 retries → `FAIL` stays 0, `RETRY_CNT`=20, pulses continue.

Source files
------------

// File: rtl/dcm_reset_seq_pkg.sv
// dcm_reset_seq_pkg: shared state encoding and retry-counter helpers for the
// DCM reset sequencer.
package dcm_reset_seq_pkg;

    // Sequencer states; encoding is fixed so debug taps stay stable.
    typedef enum logic [2:0] {
        ST_DRST   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    // Width of the retry counter exported on RETRY_CNT.
    localparam int RETRY_W = 8;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        logic [RETRY_W-1:0] r;
        if (v == {RETRY_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(RETRY_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/dcm_reset_seq_sync_bit.sv
// sync_bit: two-flop synchronizer for a single asynchronous status bit, with
// synchronous active-high reset to 0. Reusable for any cross-domain flag.
module sync_bit (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input; both stages clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/dcm_reset_seq.sv
// dcm_reset_seq: reset sequencer behind the DCM clock generator. Pulses the
// DCM reset, waits for lock, requires lock to hold for STABLE_CYCLES, then
// releases the system reset. Loss of lock re-resets the DCMs and counts a retry.
// Optional feature macro: DCM_RESET_SEQ_RETRY_LIMIT_EN -- when defined, the
// sequencer parks in FAIL once RETRY_CNT reaches MAX_RETRIES; when undefined,
// retries continue forever and FAIL is tied low.
// RST_CYCLES must be >= 3 (DCM_SP minimum reset width); TMR_W must hold
// max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) - 1.
module dcm_reset_seq
    import dcm_reset_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 15,
    parameter int TMR_W         = 17
) (
    input  logic               CLOCK_13,
    input  logic               RST,
    input  logic               LOCKED_IN,
    output logic               DCM_RST,
    output logic               SYS_RST,
    output logic               READY,
    output logic               FAIL,
    output logic [RETRY_W-1:0] RETRY_CNT
);

`ifdef DCM_RESET_SEQ_RETRY_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    // Terminal counts of the shared timer for each timed state.
    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

    state_t             state_r;
    logic [TMR_W-1:0]   timer_r;
    logic [RETRY_W-1:0] retry_cnt_r;
    logic               lock_s;
    logic               retry_block_s;

    sync_bit u_lock_sync (
        .clk (CLOCK_13),
        .rst (RST),
        .d   (LOCKED_IN),
        .q   (lock_s)
    );

    // A retry is refused only when the limit is built in and already reached.
    assign retry_block_s = LIMIT_EN && (retry_cnt_r >= RETRY_W'(MAX_RETRIES));

    // Sequencer FSM: state, shared timer and retry counter advance together.
    always_ff @(posedge CLOCK_13) begin
        if (RST) begin
            state_r     <= ST_DRST;
            timer_r     <= '0;
            retry_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_DRST: begin
                    // lock_s is deliberately ignored while the DCMs are held in reset.
                    if (timer_r == RST_LAST) begin
                        state_r <= ST_WAIT;
                        timer_r <= '0;
                    end else begin
                        timer_r <= timer_r + TMR_ONE;
                    end
                end
                ST_WAIT: begin
                    if (lock_s) begin
                        state_r <= ST_STABLE;
                        timer_r <= '0;
                    end else if (timer_r == TIMEOUT_LAST) begin
                        if (retry_block_s) begin
                            state_r <= ST_FAIL;
                            timer_r <= '0;
                        end else begin
                            state_r     <= ST_DRST;
                            timer_r     <= '0;
                            retry_cnt_r <= sat_inc(retry_cnt_r);
                        end
                    end else begin
                        timer_r <= timer_r + TMR_ONE;
                    end
                end
                ST_STABLE: begin
                    // A dropout while settling restarts the lock wait; not a retry.
                    if (!lock_s) begin
                        state_r <= ST_WAIT;
                        timer_r <= '0;
                    end else if (timer_r == STABLE_LAST) begin
                        state_r <= ST_RUN;
                        timer_r <= '0;
                    end else begin
                        timer_r <= timer_r + TMR_ONE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        if (retry_block_s) begin
                            state_r <= ST_FAIL;
                            timer_r <= '0;
                        end else begin
                            state_r     <= ST_DRST;
                            timer_r     <= '0;
                            retry_cnt_r <= sat_inc(retry_cnt_r);
                        end
                    end else begin
                        timer_r <= timer_r;
                    end
                end
                ST_FAIL: begin
                    // Terminal until RST; DCMs stay in reset.
                    state_r <= ST_FAIL;
                    timer_r <= timer_r;
                end
                default: begin
                    state_r <= ST_DRST;
                    timer_r <= '0;
                end
            endcase
        end
    end

    // Moore output decode of the state register.
    assign DCM_RST   = (state_r == ST_DRST) || (state_r == ST_FAIL);
    assign SYS_RST   = (state_r != ST_RUN);
    assign READY     = (state_r == ST_RUN);
    assign RETRY_CNT = retry_cnt_r;

`ifdef DCM_RESET_SEQ_RETRY_LIMIT_EN
    assign FAIL = (state_r == ST_FAIL);
`else
    assign FAIL = 1'b0;
`endif

endmodule

// File: tb/tb_dcm_reset_seq.sv
// tb_dcm_reset_seq: directed bench for dcm_reset_seq with a phase/countdown
// model of the sequencing rules, a per-cycle output compare and literal
// checks on reset values, pulse widths and release latencies.
module tb_dcm_reset_seq;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int TMR_W         = 17;

`ifdef DCM_RESET_SEQ_RETRY_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       LOCKED_IN = 1'b0;
    logic       DCM_RST;
    logic       SYS_RST;
    logic       READY;
    logic       FAIL;
    logic [7:0] RETRY_CNT;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    dcm_reset_seq #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .TMR_W         (TMR_W)
    ) dut (
        .CLOCK_13  (clk),
        .RST       (RST),
        .LOCKED_IN (LOCKED_IN),
        .DCM_RST   (DCM_RST),
        .SYS_RST   (SYS_RST),
        .READY     (READY),
        .FAIL      (FAIL),
        .RETRY_CNT (RETRY_CNT)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases with a "cycles remaining" countdown; lock is seen through a
    // two-sample history of LOCKED_IN.
    localparam int PH_PULSE  = 10;
    localparam int PH_SEEK   = 11;
    localparam int PH_SETTLE = 12;
    localparam int PH_LIVE   = 13;
    localparam int PH_DEAD   = 14;

    int       ph = PH_PULSE;
    int       left = RST_CYCLES;
    int       tries = 0;
    logic [1:0] hist = 2'b00;
    bit       m_valid = 1'b0;

    always @(posedge clk) begin
        if (RST) begin
            m_valid <= 1'b1;
            ph      <= PH_PULSE;
            left    <= RST_CYCLES;
            tries   <= 0;
            hist    <= 2'b00;
        end else begin
            hist <= {hist[0], LOCKED_IN};
            case (ph)
                PH_PULSE: begin
                    if (left == 1) begin ph <= PH_SEEK; left <= LOCK_TIMEOUT; end
                    else left <= left - 1;
                end
                PH_SEEK: begin
                    if (hist[1]) begin ph <= PH_SETTLE; left <= STABLE_CYCLES; end
                    else if (left == 1) begin
                        if (LIMIT && tries >= MAX_RETRIES) ph <= PH_DEAD;
                        else begin ph <= PH_PULSE; left <= RST_CYCLES; tries <= tries + 1; end
                    end else left <= left - 1;
                end
                PH_SETTLE: begin
                    if (!hist[1]) begin ph <= PH_SEEK; left <= LOCK_TIMEOUT; end
                    else if (left == 1) ph <= PH_LIVE;
                    else left <= left - 1;
                end
                PH_LIVE: begin
                    if (!hist[1]) begin
                        if (LIMIT && tries >= MAX_RETRIES) ph <= PH_DEAD;
                        else begin ph <= PH_PULSE; left <= RST_CYCLES; tries <= tries + 1; end
                    end
                end
                default: ph <= ph;
            endcase
        end
    end

    // Per-cycle compare of all outputs against the model, packed as
    // {DCM_RST, SYS_RST, READY, FAIL, RETRY_CNT}.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                int exp_v;
                int act_v;
                exp_v = {20'd0,
                         (ph == PH_PULSE || ph == PH_DEAD) ? 1'b1 : 1'b0,
                         (ph != PH_LIVE) ? 1'b1 : 1'b0,
                         (ph == PH_LIVE) ? 1'b1 : 1'b0,
                         (ph == PH_DEAD) ? 1'b1 : 1'b0,
                         (tries > 255) ? 8'd255 : 8'(tries)};
                act_v = {20'd0, DCM_RST, SYS_RST, READY, FAIL, RETRY_CNT};
                check($sformatf("cycle%0d_outputs", cyc), act_v, exp_v);
            end
        end
    end

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dcm_rst"}, DCM_RST, 1);
        check({tag, "_sys_rst"}, SYS_RST, 1);
        check({tag, "_ready"}, READY, 0);
        check({tag, "_fail"}, FAIL, 0);
        check({tag, "_retry_cnt"}, RETRY_CNT, 0);
    endtask

    // Wait (bounded) for the next 0->1 of DCM_RST; returns the cycle count.
    task automatic wait_dcm_rise(input string tag, output int t);
        int k;
        k = 0;
        while (DCM_RST && k < 100) begin @(negedge clk); k++; end
        while (!DCM_RST && k < 100) begin @(negedge clk); k++; end
        t = cyc;
        check({tag, "_rise_in_bound"}, (k < 100) ? 1 : 0, 1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        int k;
        int seen;
        int t1;
        int t2;

        // Reset values.
        RST = 1'b1;
        LOCKED_IN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");

        // Scenario 1: release, lock arrives 10 cycles later.
        tick();
        RST = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (DCM_RST) n++;
        end
        check("s1_dcm_pulse_len", n, 4);
        tick();
        LOCKED_IN = 1'b1;
        k = 0;
        while (SYS_RST && k < 40) begin tick(); k++; end
        check("s1_sys_rst_fall_latency", k, 11);
        check("s1_ready", READY, 1);
        check("s1_retry_cnt", RETRY_CNT, 0);

        // Scenario 3: one-cycle dropout in RUN.
        repeat (3) tick();
        LOCKED_IN = 1'b0;
        tick();
        LOCKED_IN = 1'b1;
        k = 1;
        while (!SYS_RST && k < 20) begin tick(); k++; end
        check("s3_sys_rst_rise_latency", k, 3);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (DCM_RST) n++;
        end
        check("s3_dcm_pulse_len", n, 4);
        check("s3_retry_cnt", RETRY_CNT, 1);
        k = 0;
        while (!READY && k < 40) begin tick(); k++; end
        check("s3_relock_ready", READY, 1);

        // Scenario 5: RST mid-RUN, then RST mid-DRST.
        tick();
        RST = 1'b1;
        tick();
        check_reset_vals("s5_run_rst");
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
        check("s5_drst_rst_dcm", DCM_RST, 1);
        check("s5_drst_rst_cnt", RETRY_CNT, 0);
        RST = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (DCM_RST) n++;
        end
        check("s5_dcm_pulse_len_after_rst", n, 4);

        // Scenario 4: dropout while STABLE timer = 5.
        tick();
        LOCKED_IN = 1'b0;
        tick();
        LOCKED_IN = 1'b1;
        k = 0;
        seen = 0;
        while (SYS_RST && k < 40) begin
            tick();
            k++;
            if (DCM_RST) seen++;
        end
        check("s4_sys_rst_fall_after_relock", k, 11);
        check("s4_no_dcm_pulse", seen, 0);
        check("s4_retry_cnt_unchanged", RETRY_CNT, 0);

        // Scenario 2 / 6: lock lost for good.
        repeat (2) tick();
        LOCKED_IN = 1'b0;
        wait_dcm_rise("s2_first", t1);
        wait_dcm_rise("s2_second", t2);
        check("s2_pulse_period", t2 - t1, RST_CYCLES + LOCK_TIMEOUT);
        if (LIMIT) begin
            k = 0;
            while (!FAIL && k < 100) begin tick(); k++; end
            check("s2_fail", FAIL, 1);
            check("s2_fail_cnt", RETRY_CNT, 2);
            check("s2_fail_dcm", DCM_RST, 1);
            check("s2_fail_sys", SYS_RST, 1);
            LOCKED_IN = 1'b1;
            repeat (20) tick();
            check("s2_fail_persists", FAIL, 1);
            check("s2_fail_dcm_persists", DCM_RST, 1);
        end else begin
            k = 0;
            seen = 0;
            while (RETRY_CNT != 8'd20 && k < 900) begin
                tick();
                k++;
                if (FAIL) seen++;
            end
            check("s6_retry_cnt", RETRY_CNT, 20);
            check("s6_fail_never", seen, 0);
            wait_dcm_rise("s6_more", t1);
            check("s6_pulses_continue", RETRY_CNT, 21);
            check("s6_fail_low", FAIL, 0);
        end

        // Final reset returns everything to reset values.
        RST = 1'b1;
        tick();
        check_reset_vals("final_rst");
        RST = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
